// File: rtl/serial_sub_ctrl_pkg.sv
// rtl/serial_sub_ctrl_pkg.sv - shared state encodings and full-subtractor equations
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-bit full subtractor p - q - bi:
  //   d  = p ^ q ^ bi
  //   bo = (q & bi) | (~p & bi) | (q & ~p)
  function automatic logic sub_diff(input logic p, input logic q, input logic bi);
    return p ^ q ^ bi;
  endfunction

  function automatic logic sub_borrow(input logic p, input logic q, input logic bi);
    return (q & bi) | (~p & bi) | (q & ~p);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// rtl/serial_sub_ctrl_cell.sv - combinational 1-bit full subtractor
module full_sub_cell
  import serial_sub_ctrl_pkg::*;
(
  input  logic p,
  input  logic q,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = sub_diff(p, q, bin);
  assign bout = sub_borrow(p, q, bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtraction controller with valid/ready handshakes
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout_out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  res_sh;
  logic [WIDTH-1:0]  res_nxt;
  logic              borrow;
  logic [CNT_W-1:0]  cnt;
  logic              cell_d;
  logic              cell_bo;
  logic              last_bit;

  full_sub_cell u_cell (
    .p    (a_sh[0]),
    .q    (b_sh[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bo)
  );

  assign last_bit = (cnt == LAST_BIT);
  // New difference bit enters at the MSB; after WIDTH shifts the word is LSB-aligned.
  assign res_nxt  = (res_sh >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);
  assign busy        = (state == ST_RUN) || (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_valid) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)    state_nxt = ST_DONE;
      ST_DONE: if (res_ready)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Operand load, per-bit shifting, borrow chaining and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      diff_out <= '0;
      bout_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            res_sh <= '0;
            borrow <= bin_in;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          borrow <= cell_bo;
          if (last_bit) begin
            // Counter parks at zero so it never runs past the last bit index.
            cnt      <= '0;
            diff_out <= res_nxt;
            bout_out <= cell_bo;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             bin_in = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] diff_out;
  logic             bout_out;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
    int               hold;
    bit               noisy;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH:0]   sb_q[$];
  int               n_checks = 0;
  int               n_fail = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .bin_in      (bin_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff_out    (diff_out),
    .bout_out    (bout_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic bin, input int hold, input bit noisy);
    vec_t v;
    logic [WIDTH:0] r;
    r = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
    v.a = a; v.b = b; v.bin = bin;
    v.exp_diff = r[WIDTH-1:0];
    v.exp_bout = r[WIDTH];
    v.hold = hold; v.noisy = noisy;
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int lat;
    logic [WIDTH:0] exp;
    @(negedge clk);
    a_in = v.a; b_in = v.b; bin_in = v.bin; start_valid = 1'b1;
    lat = 0;
    while (!start_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("start_ready before accept", start_ready, 1);
    @(posedge clk);
    sb_q.push_back({v.exp_bout, v.exp_diff});
    @(negedge clk);
    start_valid = 1'b0;
    a_in = ~v.a; b_in = WIDTH'($urandom); bin_in = ~v.bin;
    check("busy after accept", busy, 1);
    lat = 0;
    while (!res_valid && lat < 4*WIDTH) begin
      if (v.noisy) start_valid = lat[0];
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start_valid = 1'b0;
    check("latency edges", lat, WIDTH);
    if (sb_q.size() == 0) begin
      check("scoreboard entry present", 0, 1);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    check("diff_out", diff_out, exp[WIDTH-1:0]);
    check("bout_out", bout_out, exp[WIDTH]);
    for (int h = 0; h < v.hold; h++) begin
      a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); start_valid = h[0];
      @(posedge clk);
      @(negedge clk);
      check("stall res_valid", res_valid, 1);
      check("stall diff_out", diff_out, exp[WIDTH-1:0]);
      check("stall bout_out", bout_out, exp[WIDTH]);
      check("stall start_ready", start_ready, 0);
    end
    res_ready = 1'b1;
    start_valid = (v.hold > 0);
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    start_valid = 1'b0;
    check("res_valid after consume", res_valid, 0);
    check("start_ready after consume", start_ready, 1);
    check("busy after consume", busy, 0);
    if (v.noisy) begin
      repeat (3) @(negedge clk);
      check("no extra result", res_valid, 0);
      check("idle after noisy run", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset start_ready", start_ready, 1);
    check("reset res_valid", res_valid, 0);
    check("reset busy", busy, 0);
    check("reset diff_out", diff_out, 0);
    check("reset bout_out", bout_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("start_ready after release", start_ready, 1);

    vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0, 1'b0});
    vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 5, 1'b0});
    for (int i = 0; i < 6; i++) begin
      vecs.push_back(model_vec(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), i % 2, 1'b0));
    end
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i]);
    end

    @(negedge clk);
    a_in = 8'h05; b_in = 8'h03; bin_in = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back({1'b0, 8'h02});
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("midrun reset res_valid", res_valid, 0);
    check("midrun reset busy", busy, 0);
    check("midrun reset diff_out", diff_out, 0);
    check("midrun reset bout_out", bout_out, 0);
    check("midrun reset start_ready", start_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post-reset start_ready", start_ready, 1);
    check("post-reset res_valid", res_valid, 0);

    run_op('{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller. Accepts two WIDTH-bit operands and an initial borrow through a valid/ready handshake.
- Sequences a single 1-bit full-subtractor cell over WIDTH cycles, LSB first, and holds the running borrow in a flop between cycles.
- Returns the WIDTH-bit difference and the final borrow through a second valid/ready handshake.
- Sits between a requester (e.g. an ALU sequencer) and the narrow subtract datapath, trading area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  requester presents a_in, b_in and bin_in.
- start_ready  output  1  controller can accept; high only in IDLE.
- a_in  input  WIDTH  minuend P.
- b_in  input  WIDTH  subtrahend Q.
- bin_in  input  1  initial borrow-in.
- res_valid  output  1  diff_out and bout_out are valid; high only in DONE.
- res_ready  input  1  consumer accepts the result.
- diff_out  output  WIDTH  P - Q - bin, modulo 2^WIDTH.
- bout_out  output  1  final borrow-out; 1 when P < Q + bin (unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release), all values 0 at reset: state=IDLE, start_ready=1, res_valid=0, busy=0, diff_out=0, bout_out=0, operand shift registers=0, borrow flop=0, counter=0.
- Reset mid-operation: the in-flight result is discarded with no partial output. start_ready=1 on the first edge after release.
- States: IDLE, RUN, DONE. Encoding: 2-bit; the unused code returns to IDLE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: load a_sh<=a_in, b_sh<=b_in, borrow<=bin_in, cnt<=0, go to RUN.
  - Otherwise stay.
- RUN, one bit per cycle:
  - Inputs to the cell: p=a_sh[0], q=b_sh[0], bi=borrow.
  - Cell equations: d=p^q^bi; bo=(q&bi)|(~p&bi)|(q&~p).
  - Each edge: a_sh and b_sh shift right by 1; the result register shifts right with d entering at MSB; borrow<=bo; cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge: capture the final result into diff_out and the final bo into bout_out, go to DONE.
- DONE:
  - res_valid=1. diff_out and bout_out are held stable, independent of the inputs.
  - On an edge with res_ready=1: go to IDLE, res_valid<=0.
  - diff_out and bout_out keep their last values in IDLE; consumers must qualify them with res_valid.
- Latency:
  - Accept edge E0; res_valid rises after edge E0+WIDTH.
  - Throughput is one operation per WIDTH+2 cycles minimum: one cycle in DONE, and IDLE is re-entered before the next accept.
- start_valid in RUN or DONE is ignored, not queued. The requester must hold its request until start_ready is seen.
- Operand inputs are sampled only on the accept edge; later changes have no effect.
- res_ready in IDLE or RUN is ignored.
- Simultaneous res_ready and start_valid in DONE: the result is consumed. The new request is not accepted that cycle because start_ready=0.
- Counter never exceeds WIDTH-1. No wrap-around in RUN.
- All outputs are registered except start_ready, res_valid and busy, which decode directly from the state register.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - the cell equation documented once.
- One sub-module: full_sub_cell (combinational 1-bit full subtractor: ports p, q, bin -> d, bout). Instantiated once in RUN's datapath.
- The FSM, counter and shift registers stay in the top.

Test Plan:
- WIDTH=8, a_in=5, b_in=3, bin_in=0 -> diff_out=8'h02, bout_out=0. res_valid rises exactly 8 edges after the accept edge.
- a_in=3, b_in=5, bin_in=0 -> diff_out=8'hFE, bout_out=1.
- a_in=8'hFF, b_in=8'hFF, bin_in=1 -> diff_out=8'hFF, bout_out=1.
- a_in=0, b_in=0, bin_in=1 -> diff_out=8'hFF, bout_out=1.
- Backpressure, result 8'h02/bout 0:
  - hold res_ready=0 for 5 cycles in DONE, toggling a_in/b_in/start_valid -> res_valid, diff_out and bout_out stay stable; start_ready=0 throughout.
  - res_ready=1 -> IDLE on the next edge.
- Reset and ignored requests:
  - drive rst_n=0 on the 3rd RUN cycle -> all outputs 0 immediately.
  - after release, a new request 8'h10-8'h01, bin 0 -> diff_out=8'h0F, bout_out=0.
  - start_valid pulses during RUN produce no extra result.
